// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: tracks in-flight writers to drive stall, flush and forwarding selects
module pipe_hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int FWD_EN     = 1,
    parameter int BR_SLOT    = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_regwrite,
    input  logic                  issue_memread,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    logic [DEPTH-1:0]      valid_q, valid_d, regwrite_q, regwrite_d, memread_q, memread_d;
    logic [REG_ADDR_W-1:0] rd_q [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d [DEPTH];
    logic [1:0]            fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [DEPTH-1:0]      hit1, hit2;
    logic                  issue;

    // Nearest producer wins; a load in slot 0 cannot forward yet (that case stalls instead)
    function automatic logic [1:0] fwd_sel(input logic h0, input logic h1, input logic mr0);
        return (h0 && !mr0) ? 2'b10 : h1 ? 2'b01 : 2'b00;
    endfunction

    // Per-slot RAW matches for each used, non-x0 source
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i] = rs1_used && rs1 != '0 && valid_q[i] && regwrite_q[i] && rd_q[i] == rs1;
            hit2[i] = rs2_used && rs2 != '0 && valid_q[i] && regwrite_q[i] && rd_q[i] == rs2;
        end
    end

    // Hazard decisions, next scoreboard contents, forwarding selects and counters
    always_comb begin
        flush = !rst && branch_taken;
        stall = !rst && issue_valid && !branch_taken &&
                ((FWD_EN != 0) ? ((hit1[0] || hit2[0]) && memread_q[0]) : |(hit1 | hit2));
        issue = issue_valid && !stall && !flush;
        valid_d[0]    = issue;
        rd_d[0]       = issue_rd;
        regwrite_d[0] = issue_regwrite;
        memread_d[0]  = issue_memread;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i]    = valid_q[i-1] && !(flush && (i - 1) < BR_SLOT);
            rd_d[i]       = rd_q[i-1];
            regwrite_d[i] = regwrite_q[i-1];
            memread_d[i]  = memread_q[i-1];
        end
        fwd_a_d     = (issue && FWD_EN != 0) ? fwd_sel(hit1[0], hit1[1], memread_q[0]) : 2'b00;
        fwd_b_d     = (issue && FWD_EN != 0) ? fwd_sel(hit2[0], hit2[1], memread_q[0]) : 2'b00;
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            regwrite_q  <= '0;
            memread_q   <= '0;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: randomized and directed checks of both hazard modes against an issue-history model
module tb_pipe_hazard_scoreboard;
    localparam int DEPTH = 3;
    localparam int BR    = 1;

    logic       clk = 0;
    logic       rst = 1;
    logic       iv = 0, irw = 0, imr = 0, u1 = 0, u2 = 0, bt = 0;
    logic [4:0] ird = 0, r1 = 0, r2 = 0;
    logic       stall0, stall1, flush0, flush1;
    logic [1:0] fa0, fa1, fb0, fb1;
    logic [3:0]  sc0, fc0;
    logic [31:0] sc1, fc1;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(0), .BR_SLOT(BR), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_rd(ird), .issue_regwrite(irw),
        .issue_memread(imr), .rs1(r1), .rs2(r2), .rs1_used(u1), .rs2_used(u2),
        .branch_taken(bt), .stall(stall0), .flush(flush0), .fwd_a(fa0), .fwd_b(fb0),
        .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1), .BR_SLOT(BR), .CNT_W(32)) u1_dut (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_rd(ird), .issue_regwrite(irw),
        .issue_memread(imr), .rs1(r1), .rs2(r2), .rs1_used(u1), .rs2_used(u2),
        .branch_taken(bt), .stall(stall1), .flush(flush1), .fwd_a(fa1), .fwd_b(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1));

    // Model: a record of what was accepted in each past cycle; an instruction accepted in
    // cycle c sits s cycles deep (slot s) in cycle c+1+s.
    typedef struct {
        logic v;
        logic [4:0] rd;
        logic rw;
        logic mr;
        logic killed;
    } rec_t;

    rec_t   hist [2][16];
    int     now = 0;
    logic   es [2], ef [2], eiss [2];
    logic [1:0] efa [2], efb [2], nfa [2], nfb [2];
    longint ecs [2], ecf [2];
    longint cap [2] = '{15, 64'hFFFF_FFFF};

    function automatic rec_t at(int m, int s);
        return hist[m][(now - 1 - s) & 15];
    endfunction

    function automatic logic hit(int m, int s, logic [4:0] r, logic used);
        rec_t e = at(m, s);
        return used && r != 0 && e.v && !e.killed && e.rw && e.rd == r;
    endfunction

    function automatic logic [1:0] pick(int m, logic [4:0] r, logic used);
        if (hit(m, 0, r, used) && !at(m, 0).mr) return 2'b10;
        if (hit(m, 1, r, used)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) hist[m][k] = '{0, 0, 0, 0, 0};
            efa[m] = 0; efb[m] = 0; ecs[m] = 0; ecf[m] = 0;
        end
    endtask

    task automatic chk(string n, longint a, longint e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, a, e);
        end
    endtask

    task automatic drive(logic v, logic [4:0] d, logic w, logic mrd,
                         logic [4:0] a, logic [4:0] b, logic ua, logic ub, logic br);
        iv = v; ird = d; irw = w; imr = mrd; r1 = a; r2 = b; u1 = ua; u2 = ub; bt = br;
    endtask

    // Settle at the falling edge, predict this cycle, compare every output of both DUTs
    task automatic tick();
        logic any, lu;
        @(negedge clk);
        if (rst) model_clear();
        for (int m = 0; m < 2; m++) begin
            any = 0;
            for (int s = 0; s < DEPTH; s++) any |= hit(m, s, r1, u1) | hit(m, s, r2, u2);
            lu = (hit(m, 0, r1, u1) | hit(m, 0, r2, u2)) && at(m, 0).mr;
            es[m]   = !rst && iv && !bt && (m == 0 ? any : lu);
            ef[m]   = !rst && bt;
            eiss[m] = iv && !es[m] && !ef[m];
            nfa[m]  = (eiss[m] && m == 1) ? pick(m, r1, u1) : 2'b00;
            nfb[m]  = (eiss[m] && m == 1) ? pick(m, r2, u2) : 2'b00;
        end
        chk("stall_m0", stall0, es[0]);   chk("stall_m1", stall1, es[1]);
        chk("flush_m0", flush0, ef[0]);   chk("flush_m1", flush1, ef[1]);
        chk("fwd_a_m0", fa0, efa[0]);     chk("fwd_a_m1", fa1, efa[1]);
        chk("fwd_b_m0", fb0, efb[0]);     chk("fwd_b_m1", fb1, efb[1]);
        chk("stall_cnt_m0", sc0, ecs[0]); chk("stall_cnt_m1", sc1, ecs[1]);
        chk("flush_cnt_m0", fc0, ecf[0]); chk("flush_cnt_m1", fc1, ecf[1]);
    endtask

    // Commit the predicted cycle into the model, then step past the rising edge
    task automatic adv();
        if (rst) model_clear();
        else begin
            for (int m = 0; m < 2; m++) begin
                if (ef[m]) for (int s = 0; s < BR; s++) hist[m][(now - 1 - s) & 15].killed = 1;
                hist[m][now & 15] = '{eiss[m], ird, irw, imr, 1'b0};
                efa[m] = nfa[m]; efb[m] = nfb[m];
                if (es[m] && ecs[m] < cap[m]) ecs[m]++;
                if (ef[m] && ecf[m] < cap[m]) ecf[m]++;
            end
        end
        @(posedge clk);
        now++;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1; tick(); adv(); rst = 0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        do_reset();
        chk("reset_fwd_a", fa1, 0);
        chk("reset_cnt", sc1, 0);

        // Interlock: add x5,x1,x2 then add x6,x5,x3 held in Decode
        do_reset();
        drive(1, 5, 1, 0, 1, 2, 1, 1, 0); tick(); chk("t1_first", stall0, 0); adv();
        drive(1, 6, 1, 0, 5, 3, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin tick(); chk("t1_stall", stall0, 1); adv(); end
        tick(); chk("t1_issue", stall0, 0); adv();
        idle(); tick(); chk("t1_fwd", fa0, 0); chk("t1_cnt", sc0, 3); adv();

        // Load-use: lw x7 then add x8,x7,x1
        do_reset();
        drive(1, 7, 1, 1, 1, 0, 1, 0, 0); tick(); adv();
        drive(1, 8, 1, 0, 7, 1, 1, 1, 0); tick(); chk("t2_stall", stall1, 1); adv();
        tick(); chk("t2_issue", stall1, 0); adv();
        idle(); tick(); chk("t2_fwd", fa1, 1); chk("t2_cnt", sc1, 1); adv();

        // Back-to-back ALU forwarding: add x9; sub x10,x1,x9; or x11,x9
        do_reset();
        drive(1, 9, 1, 0, 1, 2, 1, 1, 0); tick(); adv();
        drive(1, 10, 1, 0, 1, 9, 1, 1, 0); tick(); chk("t3_nostall", stall1, 0); adv();
        drive(1, 11, 1, 0, 9, 0, 1, 0, 0); tick(); chk("t3_fwd_b", fb1, 2); adv();
        idle(); tick(); chk("t3_fwd_a", fa1, 1); adv();

        // x0 never creates a hazard
        do_reset();
        drive(1, 0, 1, 1, 1, 2, 1, 1, 0); tick(); adv();
        drive(1, 4, 1, 0, 0, 0, 1, 1, 0); tick();
        chk("t4_stall_m0", stall0, 0); chk("t4_stall_m1", stall1, 0); adv();
        idle(); tick(); chk("t4_fwd_a", fa1, 0); chk("t4_fwd_b", fb1, 0); adv();

        // Taken branch during a load-use match
        do_reset();
        drive(1, 7, 1, 1, 1, 0, 1, 0, 0); tick(); adv();
        drive(1, 8, 1, 0, 7, 1, 1, 1, 1); tick();
        chk("t5_flush", flush1, 1); chk("t5_stall", stall1, 0); adv();
        drive(1, 8, 1, 0, 7, 1, 1, 1, 0); tick();
        chk("t5_fwd_bubble", fa1, 0); chk("t5_fcnt", fc1, 1); chk("t5_killed", stall1, 0); adv();
        idle(); tick(); chk("t5_fwd_after", fa1, 0); adv();

        // Asynchronous reset in the middle of an interlock stall
        do_reset();
        drive(1, 5, 1, 0, 1, 2, 1, 1, 0); tick(); adv();
        drive(1, 6, 1, 0, 5, 3, 1, 1, 0); tick(); chk("t6_s1", stall0, 1); adv();
        tick(); chk("t6_s2", stall0, 1);
        rst = 1; #1;
        chk("t6_rst_stall", stall0, 0); chk("t6_rst_cnt", sc0, 0);
        adv(); tick(); adv(); rst = 0;
        tick(); chk("t6_reissue", stall0, 0); adv();
        idle(); tick(); chk("t6_cnt", sc0, 0); adv();

        // Randomized traffic over a small register set to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom % 150) == 0;
            drive(($urandom % 4) != 0, 5'($urandom % 4), ($urandom % 4) != 0, ($urandom % 3) == 0,
                  5'($urandom % 4), 5'($urandom % 4), ($urandom % 4) != 0, ($urandom % 2) == 0,
                  ($urandom % 8) == 0);
            tick(); adv();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
